// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two data-memory masters, the arbiter
// and the single data-memory port.
interface dmem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  m0_req;
   logic                  m0_we;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic [2:0]            m0_op;
   logic                  m0_ack;
   logic [DATA_WIDTH-1:0] m0_rdata;

   logic                  m1_req;
   logic                  m1_we;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic [2:0]            m1_op;
   logic                  m1_ack;
   logic [DATA_WIDTH-1:0] m1_rdata;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [2:0]            mem_op;
   logic                  mem_we;
   logic                  mem_re;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic                  busy;
   logic                  owner;

   // Requesters plus the memory model.
   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_op,
      input  m0_ack, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_op,
      input  m1_ack, m1_rdata,
      input  mem_addr, mem_wdata, mem_op, mem_we, mem_re,
      output mem_rdata,
      input  busy, owner
   );

   // The arbiter itself.
   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_op,
      output m0_ack, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_op,
      output m1_ack, m1_rdata,
      output mem_addr, mem_wdata, mem_op, mem_we, mem_re,
      input  mem_rdata,
      output busy, owner
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU load/store
// unit (master 0) and the VGA DMA copy engine (master 1), one transaction at a time.
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int READ_LAT   = 1
) (
   input  logic          clock,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // WAIT lasts READ_LAT cycles; the counter reaches zero in the last one.
   localparam logic [1:0] LP_WAIT_INIT = 2'(READ_LAT - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_busy;
   logic                  r_owner;
   logic                  r_rr_last;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [2:0]            r_op;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_wait_cnt;

   logic                  w_grant_vld;
   logic                  w_grant_id;
   logic                  w_mem_we;
   logic                  w_mem_re;
   logic                  w_ack0;
   logic                  w_ack1;

   // A tie goes to the master that did not win last time.
   always_comb begin
      w_grant_vld = bus.m0_req | bus.m1_req;
      w_grant_id  = 1'b0;
      if (bus.m0_req && bus.m1_req) begin
         w_grant_id = ~r_rr_last;
      end else if (bus.m1_req) begin
         w_grant_id = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
      w_ack0      = 1'b0;
      w_ack1      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_grant_vld) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_mem_we    = r_we;
            w_mem_re    = ~r_we;
            w_state_nxt = r_we ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            if (r_wait_cnt == 2'd0) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_ack0      = ~r_owner;
            w_ack1      = r_owner;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Transaction latch: fields are taken only at the IDLE sampling edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_owner <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_op    <= '0;
      end else if (r_state == ST_IDLE && w_grant_vld) begin
         r_owner <= w_grant_id;
         r_we    <= w_grant_id ? bus.m1_we    : bus.m0_we;
         r_addr  <= w_grant_id ? bus.m1_addr  : bus.m0_addr;
         r_wdata <= w_grant_id ? bus.m1_wdata : bus.m0_wdata;
         r_op    <= w_grant_id ? bus.m1_op    : bus.m0_op;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= 2'd0;
         r_rdata    <= '0;
         r_rr_last  <= 1'b1;
      end else begin
         if (r_state == ST_ISSUE) begin
            r_wait_cnt <= LP_WAIT_INIT;
         end else if (r_state == ST_WAIT && r_wait_cnt != 2'd0) begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
         end
         if (r_state == ST_WAIT && r_wait_cnt == 2'd0) begin
            r_rdata <= bus.mem_rdata;
         end
         if (r_state == ST_DONE) begin
            r_rr_last <= r_owner;
         end
      end
   end

   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_op    = r_op;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_re    = w_mem_re;
   assign bus.m0_ack    = w_ack0;
   assign bus.m1_ack    = w_ack1;
   // Both masters see the captured word; it is meaningful only with their ack.
   assign bus.m0_rdata  = r_rdata;
   assign bus.m1_rdata  = r_rdata;
   assign bus.busy      = r_busy;
   assign bus.owner     = r_owner;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single data-memory port (addr/din/dout/memOp/we/re) between the CPU load/store unit (master 0) and a DMA copy engine (master 1) that fills the VGA character memory. It accepts one transaction at a time and latches the winning request. It sequences that transaction onto the memory port as a one-cycle issue strobe. For reads it waits a fixed read latency, then returns an ack (with read data) to the owner. Fairness is round-robin between the two masters.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- READ_LAT, 1, memory read latency in cycles, legal 1..4

- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  request; held high with fields stable until ack
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_WIDTH  byte address
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data
- m0_op, m1_op  in  3  memOp encoding, passed through unchanged
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DATA_WIDTH  read data, valid while the matching ack is high
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_op  out  3  memory op
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high in any state other than IDLE
- owner  out  1  master currently owning the port; holds its last value in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: that master wins.
  - Both request: the master != rr_last wins.
  - On a win: latch owner, we, addr, wdata and op into registers; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive mem_addr, mem_wdata and mem_op from the latched registers.
  - Assert mem_we if we=1, otherwise assert mem_re.
  - Next state: DONE for a write, WAIT for a read.
- WAIT:
  - Lasts READ_LAT cycles, counted by a 2-bit down-counter.
  - On the edge ending the last WAIT cycle, capture mem_rdata into a rdata register; go to DONE.
- DONE (exactly 1 cycle):
  - Assert ack for the owner only.
  - The owner's rdata port shows the captured value; for a write it shows the previous captured value (don't-care).
  - Set rr_last to owner; go to IDLE.
- Output values outside active states:
  - mem_addr, mem_wdata, mem_op hold the latched values in all states.
  - mem_we and mem_re are 0 outside ISSUE.
- Requests are sampled only in IDLE:
  - A master must drop req, or present its next request, on the edge at which it samples its ack.
  - A req still high in the IDLE that follows is treated as a new transaction.
- Changes to a request's fields while it is pending but not yet sampled are legal; the values present at the IDLE sampling edge win.

## Timing
- Reset (asynchronous assert) drives:
  - state to IDLE, rr_last to 1 (so m0 wins the first tie), owner to 0;
  - all acks, mem_we, mem_re and busy to 0;
  - mem_addr, mem_wdata, mem_op and both rdata outputs to 0.
- Reset deassert: first arbitration in the next IDLE cycle.
- Latency, counting the IDLE sampling cycle as cycle 0:
  - write: ISSUE in cycle 1, ack in cycle 2;
  - read: ISSUE in cycle 1, WAIT in cycles 2..1+READ_LAT, ack in cycle 2+READ_LAT.
- Back-to-back: ack in cycle n lets a new transaction be sampled in IDLE at cycle n+1. Steady-state throughput:
  - writes: one per 3 cycles;
  - reads: one per 3+READ_LAT cycles.
- Fairness with both masters requesting continuously: grants alternate m0, m1, m0, … No master waits more than one other transaction.
- Reset mid-transaction:
  - a write already issued stays committed;
  - no ack is ever produced for the aborted transaction;
  - masters must re-request.
- busy = (state != IDLE), registered. owner is valid from ISSUE through DONE.

## Test plan
- Reset, then m0 write: addr=0x100, wdata=0xDEADBEEF, op=3'b010 → mem_we high for exactly cycle 1 with those values; m0_ack in cycle 2; m1_ack never asserts.
- READ_LAT=2, m1 read addr=0x204 with memory model returning 0x12345678 → mem_re in cycle 1; m1_ack with m1_rdata=0x12345678 in cycle 4.
- Both masters request continuously from reset (6 transactions) → owner sequence 0,1,0,1,0,1; each ack paired with its own master's address on mem_addr.
- m0 keeps req high one cycle past its ack → arbiter starts a second m0 transaction; m0 drops req on the ack edge → IDLE, busy=0.
- Assert reset during WAIT of a read → all outputs 0 immediately (asynchronously); no ack after release; a subsequent m1 write completes with its ack in cycle 2.
- READ_LAT=4 read interleaved with an m1 write request arriving during WAIT → m1 write issues in the cycle after the read's DONE plus one IDLE; mem_re and mem_we never both high.
